// File: rtl/pong_pkg.sv
// Shared game constants and the ball controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t enum, default track length and winning score (also used by the scoreboard).
package pong_pkg;

    // Default track length and winning score, kept here so the scoreboard
    // sizes its 2-bit counters from the same numbers.
    localparam int TRACK_LEN_DEF = 8;
    localparam int WIN_SCORE_DEF = 3;

    typedef enum logic [2:0] {
        SERVE_L   = 3'd0,
        SERVE_R   = 3'd1,
        MOVE_R    = 3'd2,
        MOVE_L    = 3'd3,
        HIT_HOLD  = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Raw asynchronous button -> 2-FF synchronizer -> one-cycle rising-edge press pulse.
// Latency: press_o rises 2 clk_i edges after btn_i rises; a held button gives one pulse.
// Backpressure: none; a pulse not consumed in its cycle is lost.
// Ports: clk_i, rst_n_i (async, active-low), btn_i (raw, active-high), press_o (1-cycle pulse).
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic press_o
);

    // [0] metastability stage, [1] synchronized level, [2] previous level
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], btn_i};
        end
    end

    assign press_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pong_ball_ctrl.sv
// One-dimensional pong: moves a ball along the LED track, takes paddle returns, and
// emits registered wall-hit pulses for the downstream scoreboard. Optional macro SPEEDUP_EN.
// Latency: button press to state effect is 3 cycles. Backpressure: none (free-running).
// Ports: clk_10000hz, reset (async, active-low), btn_left/btn_right (raw, async),
//        ball_led (one-hot position), left_wall_hit/right_wall_hit (HIT_PULSE-cycle pulses),
//        game_over (sticky until reset).
// SPEEDUP_EN defined: each successful return shortens the step period by 1/8, floored at
// STEP_MIN; the period snaps back to STEP_DIV on every serve.
module pong_ball_ctrl
    import pong_pkg::*;
#(
    parameter int TRACK_LEN = TRACK_LEN_DEF,
    parameter int STEP_DIV  = 2500,
    parameter int STEP_MIN  = 625,
    parameter int HIT_PULSE = 200,
    parameter int WIN_SCORE = WIN_SCORE_DEF
) (
    input  logic                 clk_10000hz,
    input  logic                 reset,
    input  logic                 btn_left,
    input  logic                 btn_right,
    output logic [TRACK_LEN-1:0] ball_led,
    output logic                 left_wall_hit,
    output logic                 right_wall_hit,
    output logic                 game_over
);

    localparam int PSW = (TRACK_LEN > 1) ? $clog2(TRACK_LEN) : 1;
    localparam int CW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    // Period register must hold both STEP_DIV and the speed-up floor.
    localparam int PW  = $clog2(((STEP_DIV > STEP_MIN) ? STEP_DIV : STEP_MIN) + 1);
    localparam int HW  = (HIT_PULSE > 1) ? $clog2(HIT_PULSE) : 1;

    localparam logic [PSW-1:0]       POS_LAST = PSW'(TRACK_LEN - 1);
    localparam logic [TRACK_LEN-1:0] LED_L    = TRACK_LEN'(1);
    localparam logic [TRACK_LEN-1:0] LED_R    = LED_L << (TRACK_LEN - 1);
    localparam logic [HW-1:0]        HOLD_END = HW'(HIT_PULSE - 1);
    localparam logic [1:0]           WIN      = 2'(WIN_SCORE);

    logic press_l, press_r;

    btn_sync_edge u_sync_left (
        .clk_i   (clk_10000hz),
        .rst_n_i (reset),
        .btn_i   (btn_left),
        .press_o (press_l)
    );

    btn_sync_edge u_sync_right (
        .clk_i   (clk_10000hz),
        .rst_n_i (reset),
        .btn_i   (btn_right),
        .press_o (press_r)
    );

    state_t               state_q;
    logic [PSW-1:0]       pos_q;
    logic [CW-1:0]        cnt_q;
    logic [HW-1:0]        hcnt_q;
    logic [1:0]           lhits_q, rhits_q;
    logic [TRACK_LEN-1:0] ball_led_q;
    logic                 left_hit_q, right_hit_q, game_over_q;

    logic [PW-1:0] period;
    logic          step_d;

`ifdef SPEEDUP_EN
    logic [PW-1:0] period_q, period_dec_d, period_ret_d;

    assign period_dec_d = period_q - (period_q >> 3);
    assign period_ret_d = (period_dec_d < PW'(STEP_MIN)) ? PW'(STEP_MIN) : period_dec_d;
    assign period       = period_q;
`else
    assign period       = PW'(STEP_DIV);
`endif

    // Terminal count of the step counter: a step happens this cycle.
    assign step_d = (PW'(cnt_q) == (period - PW'(1)));

    always_ff @(posedge clk_10000hz or negedge reset) begin
        if (!reset) begin
            state_q     <= SERVE_L;
            pos_q       <= '0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            lhits_q     <= 2'd0;
            rhits_q     <= 2'd0;
            ball_led_q  <= LED_L;
            left_hit_q  <= 1'b0;
            right_hit_q <= 1'b0;
            game_over_q <= 1'b0;
`ifdef SPEEDUP_EN
            period_q    <= PW'(STEP_DIV);
`endif
        end else begin
            case (state_q)
                SERVE_L: begin
                    if (press_l) begin
                        state_q <= MOVE_R;
                        cnt_q   <= '0;
                    end
                end

                SERVE_R: begin
                    if (press_r) begin
                        state_q <= MOVE_L;
                        cnt_q   <= '0;
                    end
                end

                MOVE_R: begin
                    // A return during the whole last-cell period beats a coincident step.
                    if (press_r && (pos_q == POS_LAST)) begin
                        state_q  <= MOVE_L;
                        cnt_q    <= '0;
`ifdef SPEEDUP_EN
                        period_q <= period_ret_d;
`endif
                    end else if (step_d) begin
                        cnt_q <= '0;
                        if (pos_q != POS_LAST) begin
                            pos_q      <= pos_q + 1'b1;
                            ball_led_q <= ball_led_q << 1;
                        end else begin
                            state_q     <= HIT_HOLD;
                            hcnt_q      <= '0;
                            right_hit_q <= 1'b1;
                            ball_led_q  <= '0;
                            rhits_q     <= (rhits_q == 2'd3) ? rhits_q : rhits_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                MOVE_L: begin
                    if (press_l && (pos_q == '0)) begin
                        state_q  <= MOVE_R;
                        cnt_q    <= '0;
`ifdef SPEEDUP_EN
                        period_q <= period_ret_d;
`endif
                    end else if (step_d) begin
                        cnt_q <= '0;
                        if (pos_q != '0) begin
                            pos_q      <= pos_q - 1'b1;
                            ball_led_q <= ball_led_q >> 1;
                        end else begin
                            state_q    <= HIT_HOLD;
                            hcnt_q     <= '0;
                            left_hit_q <= 1'b1;
                            ball_led_q <= '0;
                            lhits_q    <= (lhits_q == 2'd3) ? lhits_q : lhits_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                HIT_HOLD: begin
                    if (hcnt_q == HOLD_END) begin
                        left_hit_q  <= 1'b0;
                        right_hit_q <= 1'b0;
                        if ((lhits_q == WIN) || (rhits_q == WIN)) begin
                            state_q     <= GAME_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            // The side that just scored serves next.
                            cnt_q <= '0;
`ifdef SPEEDUP_EN
                            period_q <= PW'(STEP_DIV);
`endif
                            if (right_hit_q) begin
                                state_q    <= SERVE_R;
                                pos_q      <= POS_LAST;
                                ball_led_q <= LED_R;
                            end else begin
                                state_q    <= SERVE_L;
                                pos_q      <= '0;
                                ball_led_q <= LED_L;
                            end
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end

                GAME_OVER: begin
                    // Terminal; only reset leaves.
                end

                default: begin
                    state_q    <= SERVE_L;
                    pos_q      <= '0;
                    ball_led_q <= LED_L;
                end
            endcase
        end
    end

    assign ball_led       = ball_led_q;
    assign left_wall_hit  = left_hit_q;
    assign right_wall_hit = right_hit_q;
    assign game_over      = game_over_q;

endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
- Game-logic stage directly upstream of the 8x8 LED scoreboard.
- Moves a one-dimensional ball along a TRACK_LEN-cell LED track and accepts paddle returns from two buttons.
- Emits clean, registered left_wall_hit / right_wall_hit pulses. The scoreboard uses these as edge-triggered count inputs.
- Tracks scores internally so play stops before the scoreboard's 2-bit counters can wrap.

Parameters:
- TRACK_LEN, 8: number of ball positions / LEDs; position 0 is the left end.
- STEP_DIV, 2500: clk_10000hz cycles per ball step (4 Hz).
- STEP_MIN, 625: minimum step period; used only with SPEEDUP_EN.
- HIT_PULSE, 200: cycles a wall-hit output is held high (20 ms).
- WIN_SCORE, 3: wall hits on one side that end the game; must be ≤ 3.

Ports:
- clk_10000hz  in  1  10 kHz system tick clock.
- reset  in  1  asynchronous, active-low.
- btn_left  in  1  raw left paddle button, active-high, asynchronous.
- btn_right  in  1  raw right paddle button, active-high, asynchronous.
- ball_led  out  TRACK_LEN  one-hot ball position; bit i lit when pos==i.
- left_wall_hit  out  1  high HIT_PULSE cycles when the ball passes the left end unreturned.
- right_wall_hit  out  1  high HIT_PULSE cycles when the ball passes the right end unreturned.
- game_over  out  1  high once either side reaches WIN_SCORE.

Behaviour:
- Interface: reset reset, asynchronous, active-low; clock clk_10000hz.
- Reset values: state SERVE_L, pos=0, ball_led=1, both hit outputs 0, game_over 0, score counters 0, step counter 0, period=STEP_DIV.
- Buttons: each passes through a 2-FF synchronizer plus rising-edge detect, giving a 1-cycle press pulse. Press-to-effect latency is 3 cycles. A held button produces a single press.
- Presses are used only in the states listed below and are ignored everywhere else. A press on the side not relevant to the current state has no effect.
- SERVE_L: ball parked at pos 0. Left press -> MOVE_R, step counter cleared.
- SERVE_R: ball parked at pos TRACK_LEN-1. Right press -> MOVE_L, step counter cleared.
- MOVE_R, step counter:
  - Counts 0..period-1; at terminal count a step occurs and the counter returns to 0.
  - Step with pos<TRACK_LEN-1: pos++.
- MOVE_R, right end:
  - Return window is the whole period while pos==TRACK_LEN-1.
  - Right press in the window -> MOVE_L, counter cleared, pos unchanged.
  - Step at pos==TRACK_LEN-1 with no press -> right_wall_hit=1, ball_led=0, rhits++ (saturating), go to HIT_HOLD.
- MOVE_L: mirror of MOVE_R. Left press at pos 0 returns the ball; a miss raises left_wall_hit and increments lhits.
- HIT_HOLD: the active hit output stays high exactly HIT_PULSE cycles, then drops. On the cycle it drops:
  - If lhits or rhits equals WIN_SCORE -> GAME_OVER.
  - Else after a right hit -> SERVE_R; after a left hit -> SERVE_L.
- GAME_OVER: game_over=1, ball_led=0, all buttons ignored. Only reset exits.
- All outputs are registered and glitch-free. At most one hit output is high at a time.
- Low time between hit pulses is always ≥ TRACK_LEN·STEP_MIN cycles.
- Reset asserted mid-pulse or mid-flight clears all outputs immediately and asynchronously.
- Step counter width: $clog2(STEP_DIV). Score counters are 2 bits.

Optional Feature:
- Macro SPEEDUP_EN.
- Defined: each successful return sets period = max(period - (period>>3), STEP_MIN). Period is restored to STEP_DIV on every entry to SERVE_L or SERVE_R.
- Undefined: period is constant STEP_DIV, STEP_MIN is unused, and no subtract/compare logic is present.

Decomposition:
- Package pong_pkg holds:
  - The state enum: SERVE_L, SERVE_R, MOVE_R, MOVE_L, HIT_HOLD, GAME_OVER.
  - Default TRACK_LEN and WIN_SCORE constants, shared with the scoreboard.
- One sub-module, btn_sync_edge: 2-FF synchronizer plus rising-edge pulse, instantiated twice.

Test Plan (STEP_DIV=4, HIT_PULSE=3, TRACK_LEN=8):
- Reset -> ball_led=8'b00000001, hits 0, game_over 0. Right press ignored; ball_led unchanged.
- Left press, then idle:
  - Ball advances one cell every 4 cycles to 8'b10000000.
  - 4 cycles later right_wall_hit is high exactly 3 cycles with ball_led=0.
  - Then SERVE_R with ball_led=8'b10000000.
- Right press while ball_led=8'b10000000 -> 4 cycles later ball_led=8'b01000000; no hit pulse.
- Right press at pos 5, plus both buttons held continuously -> ignored / single press only; right_wall_hit still fires.
- Three unreturned right-end misses -> after the third 3-cycle pulse game_over=1 and ball_led=0. Further presses produce no change until reset.
- Reset asserted during a hit pulse -> hit output falls in the same cycle; state returns to reset values.
- With SPEEDUP_EN, STEP_DIV=16, STEP_MIN=8 -> successive returns give periods 14, 13, 12, 11, 10, 9, 8, 8.
